// File: rtl/vga_scanout.sv
// 640x480@60 VGA scanout: pixel timing, framebuffer fetch and registered RGB/sync outputs.
// Optional SCANOUT_TESTPATTERN_EN adds a testPattern input that replaces the image with colour bars.
module vga_scanout #(
    parameter int WIDTH        = 640,
    parameter int HEIGHT       = 480,
    parameter int H_FRONT      = 16,
    parameter int H_SYNC       = 96,
    parameter int H_BACK       = 48,
    parameter int V_FRONT      = 10,
    parameter int V_SYNC       = 2,
    parameter int V_BACK       = 33,
    parameter int CLK_DIV      = 4,
    parameter int READ_LATENCY = 1,
    parameter int COLOR_DEPTH  = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       enable,
`ifdef SCANOUT_TESTPATTERN_EN
    input  logic                       testPattern,
`endif
    output logic                       readEnable,
    output logic [12:0]                readX,
    output logic [12:0]                readY,
    input  logic [3*COLOR_DEPTH-1:0]   readVal,
    output logic [COLOR_DEPTH-1:0]     vgaRed,
    output logic [COLOR_DEPTH-1:0]     vgaGreen,
    output logic [COLOR_DEPTH-1:0]     vgaBlue,
    output logic                       hsync,
    output logic                       vsync,
    output logic                       vblank,
    output logic                       frameStart
);
    localparam int H_TOTAL = WIDTH + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = HEIGHT + V_FRONT + V_SYNC + V_BACK;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int CW      = 3 * COLOR_DEPTH;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS    = 10'(WIDTH);
    localparam logic [9:0] V_VIS    = 10'(HEIGHT);
    localparam logic [9:0] HS_START = 10'(WIDTH + H_FRONT);
    localparam logic [9:0] HS_END   = 10'(WIDTH + H_FRONT + H_SYNC);
    localparam logic [9:0] VS_START = 10'(HEIGHT + V_FRONT);
    localparam logic [9:0] VS_END   = 10'(HEIGHT + V_FRONT + V_SYNC);

    logic [DIV_W-1:0]        divCount;
    logic [9:0]              hCount;
    logic [9:0]              vCount;
    logic [12:0]             xHold;
    logic [12:0]             yHold;
    logic [READ_LATENCY-1:0] fetchPipe;
    logic [CW-1:0]           color;
    logic                    tick;
    logic                    visible;
    logic                    fetch;
    logic [CW-1:0]           pixel;

    // Read port: readEnable is a single-clock strobe with no back-pressure; the memory
    // must present readVal exactly READ_LATENCY clocks later, where it is captured.
    always_comb begin
        tick    = (divCount == DIV_LAST);
        visible = (hCount < H_VIS) && (vCount < V_VIS);
`ifdef SCANOUT_TESTPATTERN_EN
        fetch   = enable && !testPattern && (divCount == '0) && visible;
`else
        fetch   = enable && (divCount == '0) && visible;
`endif
        pixel = color;
`ifdef SCANOUT_TESTPATTERN_EN
        if (testPattern) begin
            pixel = {{COLOR_DEPTH{hCount[9]}}, {COLOR_DEPTH{hCount[8]}}, {COLOR_DEPTH{hCount[7]}}};
        end
`endif
        if (!visible) begin
            pixel = '0;
        end
        readEnable = fetch;
        readX      = fetch ? {3'b000, hCount} : xHold;
        readY      = fetch ? {3'b000, vCount} : yHold;
    end

    // Output stage is loaded on the tick, so it always shows the pixel of the period just ended.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            {divCount, hCount, vCount}  <= '0;
            {xHold, yHold}              <= '0;
            fetchPipe                   <= '0;
            color                       <= '0;
            {vgaRed, vgaGreen, vgaBlue} <= '0;
            hsync                       <= 1'b1;
            vsync                       <= 1'b1;
            vblank                      <= 1'b0;
            frameStart                  <= 1'b0;
        end else if (!enable) begin
            {divCount, hCount, vCount}  <= '0;
            {xHold, yHold}              <= '0;
            fetchPipe                   <= '0;
            color                       <= '0;
            {vgaRed, vgaGreen, vgaBlue} <= '0;
            hsync                       <= 1'b1;
            vsync                       <= 1'b1;
            vblank                      <= 1'b0;
            frameStart                  <= 1'b0;
        end else begin
            divCount <= tick ? '0 : divCount + DIV_W'(1);
            if (tick) begin
                if (hCount == H_LAST) begin
                    hCount <= '0;
                    vCount <= (vCount == V_LAST) ? '0 : vCount + 10'd1;
                end else begin
                    hCount <= hCount + 10'd1;
                end
            end
            if (fetch) begin
                xHold <= {3'b000, hCount};
                yHold <= {3'b000, vCount};
            end
            fetchPipe[0] <= fetch;
            for (int i = 1; i < READ_LATENCY; i++) begin
                fetchPipe[i] <= fetchPipe[i-1];
            end
            if (fetchPipe[READ_LATENCY-1]) begin
                color <= readVal;
            end
            if (tick) begin
                {vgaRed, vgaGreen, vgaBlue} <= pixel;
                hsync  <= !((hCount >= HS_START) && (hCount < HS_END));
                vsync  <= !((vCount >= VS_START) && (vCount < VS_END));
                vblank <= (vCount >= V_VIS);
            end
            frameStart <= tick && (vCount >= V_VIS) && !vblank;
        end
    end
endmodule

// File: tb/tb_vga_scanout.sv
// Bench for vga_scanout: a shrunken-timing instance checked against an arithmetic timing model,
// plus a default-timing instance for real line lengths. Honours SCANOUT_TESTPATTERN_EN.
module tb_vga_scanout;
    localparam int D  = 4;
    localparam int W  = 20;
    localparam int H  = 6;
    localparam int HF = 3;
    localparam int HS = 4;
    localparam int HB = 3;
    localparam int VF = 2;
    localparam int VS = 2;
    localparam int VB = 2;
    localparam int HT = W + HF + HS + HB;
    localparam int VT = H + VF + VS + VB;
    localparam int FRAME = HT * VT * D;

    logic        clock = 1'b0;
    logic        reset;
    logic        enable;
    logic        readEnable;
    logic [12:0] readX, readY;
    logic [11:0] readVal;
    logic [3:0]  vgaRed, vgaGreen, vgaBlue;
    logic        hsync, vsync, vblank, frameStart;

    logic        enableFull;
    logic        readEnableFull;
    logic [12:0] readXFull, readYFull;
    logic [11:0] readValFull;
    logic [3:0]  redFull, greenFull, blueFull;
    logic        hsyncFull, vsyncFull, vblankFull, frameStartFull;
`ifdef SCANOUT_TESTPATTERN_EN
    logic        testPattern;
    logic        testPatternFull;
`endif

    always #5 clock = ~clock;

    vga_scanout #(
        .WIDTH(W), .HEIGHT(H), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB), .CLK_DIV(D), .READ_LATENCY(1), .COLOR_DEPTH(4)
    ) dut (
        .clock(clock), .reset(reset), .enable(enable),
`ifdef SCANOUT_TESTPATTERN_EN
        .testPattern(testPattern),
`endif
        .readEnable(readEnable), .readX(readX), .readY(readY), .readVal(readVal),
        .vgaRed(vgaRed), .vgaGreen(vgaGreen), .vgaBlue(vgaBlue),
        .hsync(hsync), .vsync(vsync), .vblank(vblank), .frameStart(frameStart)
    );

    vga_scanout dutFull (
        .clock(clock), .reset(reset), .enable(enableFull),
`ifdef SCANOUT_TESTPATTERN_EN
        .testPattern(testPatternFull),
`endif
        .readEnable(readEnableFull), .readX(readXFull), .readY(readYFull), .readVal(readValFull),
        .vgaRed(redFull), .vgaGreen(greenFull), .vgaBlue(blueFull),
        .hsync(hsyncFull), .vsync(vsyncFull), .vblank(vblankFull), .frameStart(frameStartFull)
    );

    int testsRun = 0;
    int testsFailed = 0;

    // Model state: n = clock edges since enable was last seen high at an edge.
    int  n = 0;
    bit  mEn = 0;
    bit  mStrobe = 0;
    int  mX = 0, mY = 0;
    int  lastX = 0, lastY = 0;
    bit  constMode = 0;
    bit  checkModel = 1;
    int  seed = 0;
    bit  prevStrobe = 0;
    int  prevX = 0, prevY = 0;

    logic [31:0] exp_q[$];

    typedef struct {
        int          n;
        logic        re;
        logic        hs;
        logic        vs;
        logic        vb;
        logic        fs;
        logic [11:0] rgb;
    } vec_t;
    vec_t vecs[15];

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (n=%0d, t=%0t)", name, actual, expected, n, $time);
        end
    endtask

    function automatic logic [11:0] colorAt(input int x, input int y);
        if (constMode) return 12'hFFF;
        return 12'((x * 37 + y * 101 + seed) & 32'hFFF);
    endfunction

    // One clock: advance the model across the posedge, drive inputs at the negedge, then sample.
    task automatic cycle(input bit enNext);
        int pix, h, v, p, ph, pv;
        bit expStrobe, vis;
        logic [11:0] eRgb;
        logic eHs, eVs, eVb, eFs;
        @(posedge clock);
        if (mEn) begin
            if (mStrobe) begin
                lastX = mX;
                lastY = mY;
            end
            n++;
        end else begin
            n = 0;
            lastX = 0;
            lastY = 0;
        end
        @(negedge clock);
        if (constMode) readVal = 12'hFFF;
        else readVal = prevStrobe ? colorAt(prevX, prevY) : 12'($urandom);
        enable = enNext;
        mEn = enNext;
        #1;
        pix = n / D;
        h = pix % HT;
        v = (pix / HT) % VT;
        expStrobe = mEn && (n % D == 0) && (h < W) && (v < H);
        if (n < D) begin
            eRgb = '0; eHs = 1; eVs = 1; eVb = 0; eFs = 0;
        end else begin
            p = pix - 1;
            ph = p % HT;
            pv = (p / HT) % VT;
            vis = (ph < W) && (pv < H);
            eRgb = vis ? colorAt(ph, pv) : 12'h000;
            eHs = !((ph >= W + HF) && (ph < W + HF + HS));
            eVs = !((pv >= H + VF) && (pv < H + VF + VS));
            eVb = (pv >= H);
            eFs = (n % D == 0) && (ph == 0) && (pv == H);
        end
        if (checkModel) begin
            check("strobe", 32'(readEnable), 32'(expStrobe));
            check("readX", 32'(readX), expStrobe ? 32'(h) : 32'(lastX));
            check("readY", 32'(readY), expStrobe ? 32'(v) : 32'(lastY));
            check("rgb", 32'({vgaRed, vgaGreen, vgaBlue}), 32'(eRgb));
            check("hsync", 32'(hsync), 32'(eHs));
            check("vsync", 32'(vsync), 32'(eVs));
            check("vblank", 32'(vblank), 32'(eVb));
            check("frameStart", 32'(frameStart), 32'(eFs));
        end
        mStrobe = expStrobe;
        mX = h;
        mY = v;
        prevStrobe = readEnable;
        prevX = int'(readX);
        prevY = int'(readY);
    endtask

    initial begin
        int dropLeft, fsCount, lastFall, lastVFall, strobes, nf, lastFallF, fallsF;
        bit prevHs, prevVs, prevVb, prevFs, prevHsF;
        reset = 1'b1;
        enable = 1'b0;
        readVal = '0;
        enableFull = 1'b0;
        readValFull = 12'hA5C;
`ifdef SCANOUT_TESTPATTERN_EN
        testPattern = 1'b0;
        testPatternFull = 1'b0;
`endif
        #50;
        check("reset_outputs", 32'({readEnable, hsync, vsync, vblank, frameStart, vgaRed, vgaGreen, vgaBlue}),
              32'({1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 12'h000}));
        check("reset_addr", 32'({readX, readY}), 32'd0);
        #50;
        reset = 1'b0;

        // Idle with enable low.
        for (int i = 0; i < 1000; i++) cycle(1'b0);

        // Hand-derived vectors with readVal forced to FFF.
        vecs[0]  = '{0,    1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 12'h000};
        vecs[1]  = '{1,    1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 12'h000};
        vecs[2]  = '{4,    1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 12'hFFF};
        vecs[3]  = '{80,   1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 12'hFFF};
        vecs[4]  = '{84,   1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 12'h000};
        vecs[5]  = '{96,   1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 12'h000};
        vecs[6]  = '{108,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 12'h000};
        vecs[7]  = '{112,  1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 12'h000};
        vecs[8]  = '{120,  1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 12'h000};
        vecs[9]  = '{724,  1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 12'h000};
        vecs[10] = '{725,  1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 12'h000};
        vecs[11] = '{964,  1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 12'h000};
        vecs[12] = '{1204, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 12'h000};
        vecs[13] = '{1440, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 12'h000};
        vecs[14] = '{1444, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 12'hFFF};
        constMode = 1;
        cycle(1'b0);
        cycle(1'b1);
        for (int i = 0; i < 15; i++) begin
            while (n < vecs[i].n) cycle(1'b1);
            check("vec_strobe", 32'(readEnable), 32'(vecs[i].re));
            check("vec_syncs", 32'({hsync, vsync, vblank, frameStart}),
                  32'({vecs[i].hs, vecs[i].vs, vecs[i].vb, vecs[i].fs}));
            check("vec_rgb", 32'({vgaRed, vgaGreen, vgaBlue}), 32'(vecs[i].rgb));
        end

        // Drop enable mid-frame at (12,3), then restart.
        cycle(1'b0);
        constMode = 0;
        seed = int'($urandom_range(0, 4095));
        cycle(1'b1);
        while (n < D * (HT * 3 + 12)) cycle(1'b1);
        cycle(1'b0);
        check("drop_no_strobe", 32'(readEnable), 32'd0);
        cycle(1'b1);
        check("restart_idle_out", 32'({hsync, vsync, vblank, frameStart, vgaRed, vgaGreen, vgaBlue}),
              32'({1'b1, 1'b1, 1'b0, 1'b0, 12'h000}));
        check("restart_strobe", 32'({readEnable, readX, readY}), 32'({1'b1, 13'd0, 13'd0}));

        // Randomised run with occasional enable drops.
        dropLeft = 0;
        for (int i = 0; i < 8000; i++) begin
            if (dropLeft == 0 && $urandom_range(0, 799) == 0) dropLeft = int'($urandom_range(1, 6));
            if (dropLeft > 0) begin
                dropLeft--;
                cycle(1'b0);
            end else begin
                cycle(1'b1);
            end
        end

        // Three uninterrupted frames: frameStart, hsync and vsync periods.
        cycle(1'b0);
        cycle(1'b1);
        for (int k = 0; k < 3; k++) exp_q.push_back(32'(D * (HT * H + 1) + k * FRAME));
        fsCount = 0; lastFall = -1; lastVFall = -1;
        prevHs = hsync; prevVs = vsync; prevVb = vblank; prevFs = frameStart;
        while (n < 3 * FRAME + 8) begin
            cycle(1'b1);
            if (frameStart) begin
                fsCount++;
                if (prevFs) check("frameStart_width", 32'd2, 32'd1);
                check("frameStart_vblank_edge", 32'({prevVb, vblank}), 32'({1'b0, 1'b1}));
                if (exp_q.size() == 0) check("frameStart_extra", 32'(n), 32'hFFFFFFFF);
                else check("frameStart_time", 32'(n), exp_q.pop_front());
            end
            if (prevHs && !hsync) begin
                if (lastFall >= 0) check("hsync_period", 32'(n - lastFall), 32'(HT * D));
                lastFall = n;
            end
            if (!prevHs && hsync && lastFall >= 0) check("hsync_low", 32'(n - lastFall), 32'(HS * D));
            if (prevVs && !vsync) begin
                if (lastVFall >= 0) check("vsync_period", 32'(n - lastVFall), 32'(FRAME));
                lastVFall = n;
            end
            if (!prevVs && vsync && lastVFall >= 0) check("vsync_low", 32'(n - lastVFall), 32'(VS * HT * D));
            prevHs = hsync; prevVs = vsync; prevVb = vblank; prevFs = frameStart;
        end
        check("frameStart_count", 32'(fsCount), 32'd3);

        // Default-timing instance: real line length and sync widths.
        enableFull = 1'b1;
        #0;
        check("full_first_strobe", 32'({readEnableFull, readXFull, readYFull}), 32'({1'b1, 13'd0, 13'd0}));
        nf = 0; strobes = 1; lastFallF = -1; fallsF = 0; prevHsF = hsyncFull;
        while (nf < 6500) begin
            cycle(1'b1);
            nf++;
            if (readEnableFull && nf < 3200) strobes++;
            if (nf == 4 * 639) check("full_last_x", 32'({readEnableFull, readXFull}), 32'({1'b1, 13'd639}));
            if (nf == 4) check("full_rgb_first", 32'({redFull, greenFull, blueFull}), 32'h00000A5C);
            if (nf == 4 * 641) check("full_rgb_blank", 32'({redFull, greenFull, blueFull}), 32'h0);
            if (prevHsF && !hsyncFull) begin
                if (lastFallF >= 0) check("full_hsync_period", 32'(nf - lastFallF), 32'd3200);
                else check("full_hsync_first_fall", 32'(nf), 32'(4 * 657));
                lastFallF = nf;
                fallsF++;
            end
            if (!prevHsF && hsyncFull && lastFallF >= 0) check("full_hsync_low", 32'(nf - lastFallF), 32'd384);
            prevHsF = hsyncFull;
        end
        check("full_strobes_per_line", 32'(strobes), 32'd640);
        check("full_hsync_falls", 32'(fallsF), 32'd2);
        enableFull = 1'b0;

`ifdef SCANOUT_TESTPATTERN_EN
        // Colour bars: no strobes, bar index from hCount/128.
        checkModel = 0;
        testPattern = 1'b1;
        testPatternFull = 1'b1;
        cycle(1'b0);
        cycle(1'b1);
        enableFull = 1'b1;
        nf = 0; strobes = 0;
        while (nf < 2700) begin
            cycle(1'b1);
            nf++;
            if (readEnable || readEnableFull) strobes++;
            if (nf == 4) check("bar_pixel0", 32'({vgaRed, vgaGreen, vgaBlue, redFull, greenFull, blueFull}), 32'h0);
            if (nf == 4 * 201) check("bar1_full", 32'({redFull, greenFull, blueFull}), 32'h00F);
            if (nf == 4 * 640) check("bar4_full", 32'({redFull, greenFull, blueFull}), 32'hF00);
        end
        check("bar_no_strobes", 32'(strobes), 32'd0);
        enableFull = 1'b0;
        testPattern = 1'b0;
        testPatternFull = 1'b0;
        cycle(1'b0);
        checkModel = 1;
`endif

        cycle(1'b0);
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end
endmodule

// File: doc/vga_scanout.md
Name: vga_scanout

Overview:
Display-side consumer of the FrameBuffer read port. Generates 640x480@60 VGA timing from the 100 MHz system clock and issues one framebuffer read per visible pixel. Registers the returned 12-bit colour and drives 4-bit R/G/B plus active-low sync pins. Also provides a one-clock frameStart pulse at the start of vertical blank, which the draw controller uses to time clearBuffer and buffer swaps.

Parameters:
WIDTH, 640, visible pixels per line
HEIGHT, 480, visible lines per frame
H_FRONT, 16 / H_SYNC, 96 / H_BACK, 48, horizontal porch and sync widths in pixels
V_FRONT, 10 / V_SYNC, 2 / V_BACK, 33, vertical porch and sync widths in lines
CLK_DIV, 4, system clocks per pixel (100 MHz -> 25 MHz)
READ_LATENCY, 1, clocks from readEnable to valid readVal; must be <= CLK_DIV-2
COLOR_DEPTH, 4, bits per colour channel

Ports:
clock  in  1  system clock, 100 MHz
reset  in  1  asynchronous, active-high
enable  in  1  scanout run; low holds timing at origin
readEnable  out  1  framebuffer read strobe, one clock per visible pixel
readX  out  13  framebuffer read column
readY  out  13  framebuffer read row
readVal  in  3*COLOR_DEPTH  framebuffer data {R,G,B}
vgaRed/vgaGreen/vgaBlue  out  COLOR_DEPTH each  pixel colour
hsync  out  1  active-low horizontal sync
vsync  out  1  active-low vertical sync
vblank  out  1  high while the output line is >= HEIGHT
frameStart  out  1  one-clock pulse at the start of vblank

Behaviour:
- Reset (async, active-high) and enable=0: divCount=hCount=vCount=0; readEnable=0, readX=readY=0, RGB=0, hsync=1, vsync=1, vblank=0, frameStart=0. Deasserting enable mid-frame returns everything to these values on the next clock. Asserting it restarts from (0,0).
- divCount counts 0..CLK_DIV-1. A pixel tick occurs when divCount==CLK_DIV-1.
- On each tick, hCount advances 0..H_TOTAL-1 (H_TOTAL=800) and wraps. On the hCount wrap, vCount advances 0..V_TOTAL-1 (V_TOTAL=525) and wraps. Counters are 10 bits.
- Fetch: when divCount==0 and hCount<WIDTH and vCount<HEIGHT, readEnable=1 for exactly one clock, with readX=hCount and readY=vCount. Otherwise readEnable=0 and readX/readY hold their last values.
- Capture: readVal is sampled READ_LATENCY clocks after readEnable into a colour register.
- Output stage (all registered, updated on tick): all outputs describe the pixel fetched in the previous pixel period. Every output lags the counters by exactly CLK_DIV clocks.
- RGB = captured colour when the lagged position is visible; otherwise 0, regardless of readVal.
- hsync=0 when lagged hCount is in [656,751]. vsync=0 when lagged vCount is in [490,491]. vblank=1 when lagged vCount >= 480.
- frameStart=1 for one clock on the tick where vblank goes 0->1. Exactly one pulse per frame.
- Frame period is 800*525*CLK_DIV = 1,680,000 clocks. Line period is 3200 clocks, with hsync low for 384 clocks.

Optional Feature:
SCANOUT_TESTPATTERN_EN
- Defined: adds input port testPattern (1 bit).
- When testPattern=1: readEnable stays 0 and the visible RGB becomes eight vertical bars. The bar index is lagged hCount[9:7] (hCount/128); R=bar[2]?F:0, G=bar[1]?F:0, B=bar[0]?F:0. Timing and blanking are unchanged.
- Not defined: no port, no pattern logic; behaviour is exactly as above.

Test Plan:
- Reset held 100 ns then released with enable=0 -> all outputs at reset values for 1000 clocks, with no readEnable.
- enable=1, framebuffer returns readVal=12'hA5C -> first readEnable at divCount 0 with (0,0); vgaRed=A, vgaGreen=5, vgaBlue=C from CLK_DIV clocks later; exactly 640 strobes per line.
- Free run -> hsync falling edges 3200 clocks apart, each 384 clocks low; vsync low for 6400 clocks every 1,680,000 clocks.
- readVal forced 12'hFFF -> RGB=0 during every horizontal and vertical blanking interval; no readEnable during lines 480..524.
- Run 3 frames -> exactly 3 frameStart pulses, each one clock wide, 1,680,000 clocks apart, coincident with the vblank rising edge.
- Drop enable at hCount=300, vCount=100, then reassert -> outputs idle the next clock; the next strobe is at (0,0). With SCANOUT_TESTPATTERN_EN and testPattern=1 -> pixel 0 RGB=000, pixel 896-128*7 region (hCount 896 invalid) i.e. hCount 640-1 bar 4 -> RGB=F00, and no strobes.
